// File: rtl/ieeedrv_sd_arbiter.sv
// rtl/ieeedrv_sd_arbiter.sv - round-robin arbiter of NBD block-device requesters onto one SD host port
// Optional watchdog on the REQ phase: define IEEEDRV_SD_ARB_TIMEOUT_EN.
module ieeedrv_sd_arbiter #(
  parameter int NBD   = 2,
  parameter int TMO_W = 24
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [31:0]     req_lba      [NBD],
  input  logic [5:0]      req_blk_cnt  [NBD],
  input  logic [NBD-1:0]  req_rd,
  input  logic [NBD-1:0]  req_wr,
  output logic [NBD-1:0]  req_ack,
  input  logic [7:0]      req_buff_din [NBD],
  output logic [31:0]     sd_lba,
  output logic [5:0]      sd_blk_cnt,
  output logic            sd_rd,
  output logic            sd_wr,
  input  logic            sd_ack,
  output logic [7:0]      sd_buff_din,
  output logic [2:0]      grant,
  output logic            busy,
  output logic            tmo_err
);

  if (NBD < 1 || NBD > 8 || TMO_W < 1) begin : g_bad_cfg
    $error("ieeedrv_sd_arbiter: NBD must be 1..8 and TMO_W at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr;
  logic [2:0]  ptr_adv;
  logic        op_rd;
  logic [7:0]  pend8;
  logic [3:0]  cand;
  logic        found;
  logic [2:0]  pick;
  logic        pick_rd;
  logic [31:0] pick_lba;
  logic [5:0]  pick_cnt;
  logic        tmo_hit;

  // First pending requester at or after ptr, wrapping at NBD.
  always_comb begin
    pend8 = '0;
    pend8[NBD-1:0] = req_rd | req_wr;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NBD; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NBD)) cand = cand - 4'(NBD);
      if (!found && pend8[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  always_comb begin
    pick_rd     = 1'b0;
    pick_lba    = '0;
    pick_cnt    = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NBD; i++) begin
      if (pick == 3'(i)) begin
        pick_rd  = req_rd[i];
        pick_lba = req_lba[i];
        pick_cnt = req_blk_cnt[i];
      end
      if (grant == 3'(i)) sd_buff_din = req_buff_din[i];
    end
  end

  assign ptr_adv = (grant == 3'(NBD - 1)) ? 3'd0 : grant + 3'd1;

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] wdog;

  // Held at zero outside REQ, so every REQ entry starts from a cleared count.
  always_ff @(posedge clk_sys) begin
    if (reset || state != S_REQ) wdog <= '0;
    else                         wdog <= wdog + 1'b1;
  end

  assign tmo_hit = (state == S_REQ) && !sd_ack && (&wdog);
`else
  assign tmo_hit = 1'b0;
`endif

  assign tmo_err = tmo_hit;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sd_rd     = 1'b0;
    sd_wr     = 1'b0;
    req_ack   = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (found) state_nxt = S_REQ;
      S_REQ: begin
        sd_rd = op_rd && !tmo_hit;
        sd_wr = !op_rd && !tmo_hit;
        if (sd_ack)       state_nxt = S_XFER;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_XFER: begin
        for (int i = 0; i < NBD; i++) req_ack[i] = (grant == 3'(i));
        if (!sd_ack) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Host-side command is frozen at grant time; requester changes afterwards are ignored.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ptr        <= '0;
      grant      <= '0;
      op_rd      <= 1'b0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
    end else begin
      if (state == S_IDLE && found) begin
        grant      <= pick;
        op_rd      <= pick_rd;
        sd_lba     <= pick_lba;
        sd_blk_cnt <= pick_cnt;
      end
      if (state == S_DONE || tmo_hit) ptr <= ptr_adv;
    end
  end

endmodule

// File: doc/ieeedrv_sd_arbiter.md
IEEEDRV_SD_ARBITER -- requirements
Module: ieeedrv_sd_arbiter

Interface
REQ-001 The block SHALL have parameter NBD, default 2, giving the number of block-device requesters (range 1..8).
REQ-002 The block SHALL have parameter TMO_W, default 24, giving the watchdog counter width.
REQ-003 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_lba[NBD]  in  32  per-requester block address.
REQ-006 req_blk_cnt[NBD]  in  6  per-requester block count minus one.
REQ-007 req_rd  in  NBD  per-requester read request, level, held until its ack.
REQ-008 req_wr  in  NBD  per-requester write request, level, held until its ack.
REQ-009 req_ack  out  NBD  per-requester ack, one-hot or zero.
REQ-010 req_buff_din[NBD]  in  8  per-requester write data.
REQ-011 sd_lba  out  32  host block address.
REQ-012 sd_blk_cnt  out  6  host block count.
REQ-013 sd_rd / sd_wr  out  1 each  host request strobes.
REQ-014 sd_ack  in  1  host acknowledge, high for whole transfer.
REQ-015 sd_buff_din  out  8  write data to host.
REQ-016 grant  out  3  index of current/last granted requester.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 tmo_err  out  1  one-cycle pulse on watchdog abort (macro only; constant 0 otherwise).

Function
REQ-019 The FSM SHALL have states IDLE, REQ, XFER, DONE.
REQ-020 IDLE: if any req_rd|req_wr set, SHALL select the first pending index searching round-robin from ptr, latch index into grant, latch lba/blk_cnt/op, go to REQ next cycle.
REQ-021 Same requester with rd and wr both set: read SHALL win.
REQ-022 REQ: sd_rd or sd_wr (per latched op) SHALL be high; on sd_ack=1 SHALL go to XFER, dropping sd_rd/sd_wr the same edge.
REQ-023 XFER: req_ack[grant] SHALL equal 1, all other req_ack bits 0; on sd_ack=0 SHALL go to DONE.
REQ-024 DONE: one cycle, ptr SHALL become grant+1 wrapping NBD-1 -> 0, then IDLE.
REQ-025 sd_lba and sd_blk_cnt SHALL hold latched values from REQ entry until the next grant; requester changes during REQ/XFER SHALL be ignored.
REQ-026 sd_buff_din SHALL equal req_buff_din[grant] combinationally in every state.
REQ-027 Grant latency SHALL be exactly 1 cycle from request visible in IDLE to sd_rd/sd_wr high.
REQ-028 Requests from non-granted requesters SHALL stay pending untouched; no request lost.
REQ-029 sd_ack already high when entering REQ SHALL be treated as a fresh ack (XFER next cycle).
REQ-030 Requester dropping its request while in REQ SHALL NOT cancel the host transaction.

Reset
REQ-031 On reset: state IDLE, ptr 0, grant 0, sd_rd/sd_wr 0, req_ack 0, sd_lba 0, sd_blk_cnt 0, busy 0, tmo_err 0, watchdog 0.
REQ-032 Reset mid-transfer SHALL abort immediately with no ack to any requester.

Configuration
REQ-033 Macro IEEEDRV_SD_ARB_TIMEOUT_EN: when defined, a TMO_W-bit counter SHALL clear on REQ entry and count each REQ cycle; at all-ones it SHALL drop sd_rd/sd_wr, pulse tmo_err, advance ptr as in DONE, return to IDLE.
REQ-034 Without the macro there SHALL be no counter, REQ waits indefinitely, tmo_err tied 0.

Verification
REQ-035 req_rd=01, req_lba[0]=0x123 -> sd_rd high 1 cycle later, sd_lba=0x123; sd_ack 1 for 256 cycles -> req_ack=01 for those 256 cycles.
REQ-036 req_rd=11 same cycle after reset -> requester 0 served first, then requester 1; grant 0 then 1.
REQ-037 Requester 0 re-requests immediately after DONE while requester 1 pending -> requester 1 served before requester 0.
REQ-038 req_rd[1]=req_wr[1]=1 -> sd_rd=1, sd_wr=0; sd_buff_din tracks req_buff_din[1].
REQ-039 reset asserted during XFER -> next cycle all outputs zero, state IDLE.
REQ-040 With IEEEDRV_SD_ARB_TIMEOUT_EN, TMO_W=4, no sd_ack -> tmo_err pulse after 15 REQ cycles, sd_rd drops, busy 0 within 1 cycle.
